serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter d, default 4, setting the operand and difference width in bits; the legal range SHALL be d >= 2.
REQ-002 Port clk SHALL be an input of width 1: the single clock, with all state updated on its rising edge.
REQ-003 Port rst_n SHALL be an input of width 1: the reset, asynchronous and active-low.
REQ-004 Port start SHALL be an input of width 1: the operation request, sampled only in IDLE.
REQ-005 Port a SHALL be an input of width d: the minuend.
REQ-006 Port b SHALL be an input of width d: the subtrahend.
REQ-007 Port bin SHALL be an input of width 1: the borrow-in.
REQ-008 Port busy SHALL be an output of width 1, high while an operation is in progress.
REQ-009 Port done SHALL be an output of width 1, high for one cycle when a result becomes valid.
REQ-010 Port diff SHALL be an output of width d: the registered result a - b - bin, modulo 2^d.
REQ-011 Port bout SHALL be an output of width 1: the registered borrow-out, high when a < b + bin (unsigned).

Function
REQ-012 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL capture a, b and bin into internal shift/borrow registers, clear the bit counter to 0, and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE and leave diff and bout unchanged.
REQ-015 In RUN, each rising edge SHALL process exactly one bit, LSB first: bit i = a_i ^ b_i ^ br, and br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br).
REQ-016 The bit counter SHALL increment once per RUN edge; on the edge that processes bit d-1, the block SHALL load the full result into diff, load the final borrow into bout, and enter DONE.
REQ-017 Latency: with start accepted at edge N, done SHALL be high in the cycle following edge N+d, so an operation takes exactly d RUN edges.
REQ-018 In DONE, done SHALL be 1 and busy SHALL be 0; the next edge SHALL return the block to IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly while in RUN.
REQ-020 start SHALL be ignored in RUN and in DONE; no restart and no abort SHALL occur.
REQ-021 Changes on a, b or bin after capture SHALL NOT affect the operation in progress.
REQ-022 diff and bout SHALL hold their last result from one DONE until the next DONE, and SHALL never show partial results.
REQ-023 With start held high continuously, a new operation SHALL begin every d+2 cycles (IDLE, then d RUN cycles, then DONE).
REQ-024 Wrap-around: when a < b + bin, diff SHALL equal a - b - bin + 2^d, with bout = 1.
REQ-025 When a = b and bin = 0, the block SHALL produce diff = 0 and bout = 0.

Reset
REQ-026 When rst_n = 0, the block SHALL immediately (without a clock) force the state to IDLE, clear the counter, shift registers and borrow, and drive busy, done, diff and bout to 0.
REQ-027 Reset asserted in mid-RUN or in DONE SHALL discard the operation, and no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first start SHALL be accepted at the first rising edge on which start is seen in IDLE.

Verification (d=4)
REQ-029 The bench SHALL apply a=1001, b=1000, bin=1 -> diff=0000, bout=0, with done exactly 4 edges after the accepting edge.
REQ-030 The bench SHALL apply a=1010, b=1011, bin=0 -> diff=1111, bout=1.
REQ-031 The bench SHALL apply a=1100, b=1101, bin=1 -> diff=1110, bout=1; and a=0101, b=1011, bin=0 -> diff=1010, bout=1.
REQ-032 The bench SHALL pulse start again in RUN and change a/b mid-operation -> the result is unaffected, with exactly one done pulse.
REQ-033 The bench SHALL assert rst_n low after 2 RUN edges -> all outputs 0 at once, no done pulse, and a subsequent operation with a=0000, b=0000, bin=1 -> diff=1111, bout=1.
REQ-034 The bench SHALL hold start high for 3 operations -> done pulses spaced 6 cycles apart, with diff/bout stable between pulses.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and publishes the full difference and borrow-out only when the last bit is done.
module serial_subtractor #(
  parameter int d = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [d-1:0] a,
  input  logic [d-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [d-1:0] diff,
  output logic         bout
);

  localparam int CW = $clog2(d);
  localparam logic [CW-1:0] LAST = CW'(d - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [d-1:0]   a_sh_q, a_sh_d;
  logic [d-1:0]   b_sh_q, b_sh_d;
  logic [d-1:0]   res_q, res_d;
  logic           br_q, br_d;
  logic [d-1:0]   diff_q, diff_d;
  logic           bout_q, bout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           a_i, b_i, bit_i, br_nx;
  logic [d-1:0]   res_nx;

  // One full-subtractor cell applied to the current LSBs of the shift registers.
  always_comb begin
    a_i    = a_sh_q[0];
    b_i    = b_sh_q[0];
    bit_i  = a_i ^ b_i ^ br_q;
    br_nx  = (~a_i & b_i) | (~a_i & br_q) | (b_i & br_q);
    res_nx = {bit_i, res_q[d-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_nx;
        res_d  = res_nx;
        cnt_d  = cnt_q + CW'(1);
        // Outputs change only here, so partial results are never visible.
        if (cnt_q == LAST) begin
          diff_d  = res_nx;
          bout_d  = br_nx;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
